// File: rtl/spi_pkg.sv
// Shared SPI definitions: limits, idle clock level, FSM encoding and the
// byte-placement helpers common to the master and the responder.
package spi_pkg;

    localparam int unsigned SPI_MAX_BYTES  = 4;
    localparam logic        SPI_CLOCK_IDLE = 1'b0;
    localparam logic [2:0]  SPI_MAX_CNT    = 3'(SPI_MAX_BYTES);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

    // Byte number idx of a transaction lands at [8*(3-idx)+:8]; first byte in the MSBs.
    function automatic logic [31:0] spi_place_byte(input logic [31:0] word,
                                                   input logic [7:0]  data,
                                                   input logic [2:0]  idx);
        logic [31:0] res;
        res = word;
        case (idx)
            3'd0:    res[31:24] = data;
            3'd1:    res[23:16] = data;
            3'd2:    res[15:8]  = data;
            3'd3:    res[7:0]   = data;
            default: res        = word;
        endcase
        return res;
    endfunction

    function automatic logic [2:0] spi_clamp_count(input logic [2:0] n);
        return (n > SPI_MAX_CNT) ? SPI_MAX_CNT : n;
    endfunction

    // rem counts bytes still to send including the current one, so the byte sits at 8*(rem-1).
    function automatic logic spi_reply_bit(input logic [31:0] word,
                                           input logic [2:0]  rem,
                                           input logic [2:0]  bit_idx);
        logic [4:0] sel;
        sel = 5'({rem - 3'd1, bit_idx});
        return word[sel];
    endfunction

endpackage

// File: rtl/spi_input_sync.sv
// Multi-flop synchronizer for one SPI pin with registered-history edge pulses.
// Edges are suppressed until the pipeline holds real pin samples after reset.
module spi_input_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [SYNC_STAGES:0]   warm_q, warm_d;
    logic                   level;

    assign level = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
        prev_d = level;
        warm_d = {warm_q[SYNC_STAGES-1:0], 1'b1};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
            warm_q <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            warm_q <= warm_d;
        end
    end

    // A pin held at the non-reset level through reset must not look like an edge.
    assign rise_o = warm_q[SYNC_STAGES] &  level & ~prev_q;
    assign fall_o = warm_q[SYNC_STAGES] & ~level &  prev_q;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI mode-0 responder oversampled in the clk_i domain: collects up to four
// received bytes and shifts a preloaded reply out on MISO.
module spi_slave_responder
    import spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        spi_clk_i,
    input  logic        spi_cs_n_i,
    input  logic        spi_mosi_i,
    output logic        spi_miso_o,
    input  logic [31:0] tx_data_i,
    input  logic [2:0]  tx_bytes_valid_i,
    input  logic        tx_load_i,
    output logic        tx_ready_o,
    output logic [31:0] rx_data_o,
    output logic [2:0]  rx_bytes_valid_o,
    output logic        rx_byte_strobe_o,
    output logic        rx_done_o,
    output logic        overflow_o
);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(SPI_CLOCK_IDLE)) u_sclk_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (spi_clk_i),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (spi_cs_n_i),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    spi_state_t             state_q, state_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [6:0]             shift_q, shift_d;
    logic [31:0]            rx_data_q, rx_data_d;
    logic [2:0]             rx_cnt_q, rx_cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   strobe_q, strobe_d;
    logic                   done_q, done_d;
    logic                   miso_q, miso_d;
    logic [31:0]            tx_buf_q, tx_buf_d;
    logic [2:0]             tx_n_q, tx_n_d;
    logic [2:0]             tx_rem_q, tx_rem_d;
    logic [2:0]             tx_bit_q, tx_bit_d;
    logic                   pending_q, pending_d;
    logic                   ready_q, ready_d;

    logic        load_ok;
    logic [7:0]  byte_v;
    logic [2:0]  rem_start, rem_next;
    logic [31:0] first_word;

    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d     = state_q;
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_cnt_d    = rx_cnt_q;
        ovf_d       = ovf_q;
        strobe_d    = 1'b0;
        done_d      = 1'b0;
        miso_d      = miso_q;
        tx_buf_d    = tx_buf_q;
        tx_n_d      = tx_n_q;
        tx_rem_d    = tx_rem_q;
        tx_bit_d    = tx_bit_q;
        pending_d   = pending_q;
        byte_v      = {shift_q, mosi_s};
        rem_start   = '0;
        rem_next    = '0;
        first_word  = tx_buf_q;

        load_ok = tx_load_i & ready_q;
        if (load_ok) begin
            tx_buf_d  = tx_data_i;
            tx_n_d    = spi_clamp_count(tx_bytes_valid_i);
            pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = ACTIVE;
                    bit_cnt_d = 3'd7;
                    shift_d   = '0;
                    rx_data_d = '0;
                    rx_cnt_d  = '0;
                    ovf_d     = 1'b0;
                    tx_bit_d  = 3'd7;
                    // A load in this very cycle is not in tx_buf_q yet; take it from the port.
                    if (load_ok) begin
                        rem_start  = spi_clamp_count(tx_bytes_valid_i);
                        first_word = tx_data_i;
                    end else if (pending_q) begin
                        rem_start  = tx_n_q;
                    end
                    tx_rem_d = rem_start;
                    miso_d   = (rem_start != 3'd0) ? spi_reply_bit(first_word, rem_start, 3'd7) : 1'b0;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    pending_d = 1'b0;
                    miso_d    = 1'b0;
                end else begin
                    if (sclk_rise) begin
                        shift_d = byte_v[6:0];
                        if (bit_cnt_q == 3'd0) begin
                            bit_cnt_d = 3'd7;
                            if (rx_cnt_q < SPI_MAX_CNT) begin
                                rx_data_d = spi_place_byte(rx_data_q, byte_v, rx_cnt_q);
                                rx_cnt_d  = rx_cnt_q + 3'd1;
                                strobe_d  = 1'b1;
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q - 3'd1;
                        end
                    end
                    if (sclk_fall) begin
                        if (tx_bit_q == 3'd0) begin
                            rem_next = (tx_rem_q == 3'd0) ? 3'd0 : tx_rem_q - 3'd1;
                            tx_rem_d = rem_next;
                            tx_bit_d = 3'd7;
                            miso_d   = (rem_next != 3'd0) ? spi_reply_bit(tx_buf_q, rem_next, 3'd7) : 1'b0;
                        end else begin
                            tx_bit_d = tx_bit_q - 3'd1;
                            miso_d   = (tx_rem_q != 3'd0) ? spi_reply_bit(tx_buf_q, tx_rem_q, tx_bit_q - 3'd1) : 1'b0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE) && !pending_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            mosi_sync_q <= '0;
            bit_cnt_q   <= 3'd7;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_cnt_q    <= '0;
            ovf_q       <= 1'b0;
            strobe_q    <= 1'b0;
            done_q      <= 1'b0;
            miso_q      <= 1'b0;
            tx_buf_q    <= '0;
            tx_n_q      <= '0;
            tx_rem_q    <= '0;
            tx_bit_q    <= 3'd7;
            pending_q   <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            mosi_sync_q <= mosi_sync_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_cnt_q    <= rx_cnt_d;
            ovf_q       <= ovf_d;
            strobe_q    <= strobe_d;
            done_q      <= done_d;
            miso_q      <= miso_d;
            tx_buf_q    <= tx_buf_d;
            tx_n_q      <= tx_n_d;
            tx_rem_q    <= tx_rem_d;
            tx_bit_q    <= tx_bit_d;
            pending_q   <= pending_d;
            ready_q     <= ready_d;
        end
    end

    assign spi_miso_o       = miso_q;
    assign tx_ready_o       = ready_q;
    assign rx_data_o        = rx_data_q;
    assign rx_bytes_valid_o = rx_cnt_q;
    assign rx_byte_strobe_o = strobe_q;
    assign rx_done_o        = done_q;
    assign overflow_o       = ovf_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder acting as a mode-0 SPI master.
module tb_spi_slave_responder;

    localparam int HP = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_clk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic [31:0] tx_data = '0;
    logic [2:0]  tx_valid = '0;
    logic        tx_load = 1'b0;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic [2:0]  rx_cnt;
    logic        rx_byte_strobe_o;
    logic        rx_done_o;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;
    int done_cnt = 0;
    int miso_hi_cnt = 0;

    always #5 clk = ~clk;

    spi_slave_responder #(.SYNC_STAGES(2)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .spi_clk_i        (spi_clk),
        .spi_cs_n_i       (spi_cs_n),
        .spi_mosi_i       (spi_mosi),
        .spi_miso_o       (spi_miso),
        .tx_data_i        (tx_data),
        .tx_bytes_valid_i (tx_valid),
        .tx_load_i        (tx_load),
        .tx_ready_o       (tx_ready),
        .rx_data_o        (rx_data),
        .rx_bytes_valid_o (rx_cnt),
        .rx_byte_strobe_o (rx_byte_strobe_o),
        .rx_done_o        (rx_done_o),
        .overflow_o       (overflow)
    );

    always @(posedge clk) begin
        if (rx_byte_strobe_o) strobe_cnt <= strobe_cnt + 1;
        if (rx_done_o)        done_cnt   <= done_cnt + 1;
        if (spi_miso)         miso_hi_cnt <= miso_hi_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Shift nbits of mo (MSB first), capturing MISO just before each rising edge.
    task automatic spi_bits(input logic [7:0] mo, input int nbits,
                            output logic [7:0] mi, output int lat);
        mi  = '0;
        lat = 0;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = mo[i];
            wait_clk(HP);
            mi[i]   = spi_miso;
            spi_clk = 1'b1;
            for (int k = 1; k <= HP; k++) begin
                @(posedge clk);
                #1;
                if (lat == 0 && rx_byte_strobe_o) lat = k;
            end
            spi_clk = 1'b0;
        end
    endtask

    task automatic cs_begin();
        spi_cs_n = 1'b0;
        wait_clk(HP);
    endtask

    task automatic cs_finish(output int lat);
        wait_clk(HP);
        spi_cs_n = 1'b1;
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (lat == 0 && rx_done_o) lat = k;
        end
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_miso"},   32'(spi_miso), 32'd0);
        check({pfx, "_ready"},  32'(tx_ready), 32'd1);
        check({pfx, "_rxdata"}, rx_data, 32'd0);
        check({pfx, "_rxcnt"},  32'(rx_cnt), 32'd0);
        check({pfx, "_strobe"}, 32'(rx_byte_strobe_o), 32'd0);
        check({pfx, "_done"},   32'(rx_done_o), 32'd0);
        check({pfx, "_ovf"},    32'(overflow), 32'd0);
    endtask

    initial begin
        logic [7:0] mi;
        int lat, dlat, s0, d0, m0;

        // Reset state
        wait_clk(3);
        check_reset_values("rst");
        rst = 1'b0;
        wait_clk(10);

        // Two-byte exchange
        check("t1_ready_pre", 32'(tx_ready), 32'd1);
        tx_data = 32'h0000_A55A; tx_valid = 3'd2; tx_load = 1'b1;
        wait_clk(1);
        tx_load = 1'b0;
        check("t1_ready_fall", 32'(tx_ready), 32'd0);
        s0 = strobe_cnt; d0 = done_cnt;
        cs_begin();
        spi_bits(8'h12, 8, mi, lat);
        check("t1_miso_b0", 32'(mi), 32'hA5);
        check("t1_strobe_lat", 32'(lat), 32'd3);
        check("t1_cnt_b0", 32'(rx_cnt), 32'd1);
        spi_bits(8'h34, 8, mi, lat);
        check("t1_miso_b1", 32'(mi), 32'h5A);
        cs_finish(dlat);
        check("t1_done_lat", 32'(dlat), 32'd3);
        check("t1_rxdata", rx_data, 32'h1234_0000);
        check("t1_rxcnt", 32'(rx_cnt), 32'd2);
        check("t1_strobes", 32'(strobe_cnt - s0), 32'd2);
        check("t1_dones", 32'(done_cnt - d0), 32'd1);
        check("t1_ready_post", 32'(tx_ready), 32'd1);
        check("t1_ovf", 32'(overflow), 32'd0);

        // Overflow with no reply loaded
        s0 = strobe_cnt; d0 = done_cnt; m0 = miso_hi_cnt;
        cs_begin();
        for (int b = 1; b <= 5; b++) begin
            spi_bits(8'(b), 8, mi, lat);
            check("t2_miso_byte", 32'(mi), 32'h00);
        end
        cs_finish(dlat);
        check("t2_rxdata", rx_data, 32'h0102_0304);
        check("t2_rxcnt", 32'(rx_cnt), 32'd4);
        check("t2_ovf", 32'(overflow), 32'd1);
        check("t2_strobes", 32'(strobe_cnt - s0), 32'd4);
        check("t2_miso_high", 32'(miso_hi_cnt - m0), 32'd0);
        check("t2_dones", 32'(done_cnt - d0), 32'd1);

        // Abort mid-byte
        s0 = strobe_cnt; d0 = done_cnt;
        cs_begin();
        check("t3_ovf_cleared", 32'(overflow), 32'd0);
        spi_bits(8'hC3, 8, mi, lat);
        spi_bits(8'hFF, 3, mi, lat);
        cs_finish(dlat);
        check("t3_rxdata", rx_data, 32'hC300_0000);
        check("t3_rxcnt", 32'(rx_cnt), 32'd1);
        check("t3_dones", 32'(done_cnt - d0), 32'd1);
        check("t3_strobes", 32'(strobe_cnt - s0), 32'd1);

        // Clamped reply count, load while ACTIVE ignored
        tx_data = 32'hDEAD_BEEF; tx_valid = 3'd7; tx_load = 1'b1;
        wait_clk(1);
        tx_load = 1'b0;
        cs_begin();
        spi_bits(8'h00, 8, mi, lat);
        check("t4_miso_b0", 32'(mi), 32'hDE);
        check("t4_ready_active", 32'(tx_ready), 32'd0);
        tx_data = 32'h1122_3344; tx_valid = 3'd4; tx_load = 1'b1;
        wait_clk(2);
        tx_load = 1'b0;
        spi_bits(8'h00, 8, mi, lat);
        check("t4_miso_b1", 32'(mi), 32'hAD);
        spi_bits(8'h00, 8, mi, lat);
        check("t4_miso_b2", 32'(mi), 32'hBE);
        spi_bits(8'h00, 8, mi, lat);
        check("t4_miso_b3", 32'(mi), 32'hEF);
        cs_finish(dlat);
        check("t4_ready_post", 32'(tx_ready), 32'd1);
        check("t4_rxcnt", 32'(rx_cnt), 32'd4);

        // Reset mid-transaction
        cs_begin();
        spi_bits(8'hAA, 8, mi, lat);
        spi_bits(8'hF0, 4, mi, lat);
        rst = 1'b1;
        wait_clk(2);
        check_reset_values("t5_inrst");
        rst = 1'b0;
        wait_clk(10);
        check_reset_values("t5_post");
        s0 = strobe_cnt; d0 = done_cnt;
        spi_bits(8'hFF, 8, mi, lat);
        check("t5_no_strobe", 32'(strobe_cnt - s0), 32'd0);
        wait_clk(HP);
        spi_cs_n = 1'b1;
        wait_clk(HP + 4);
        check("t5_no_done", 32'(done_cnt - d0), 32'd0);
        check("t5_rxcnt_idle", 32'(rx_cnt), 32'd0);
        cs_begin();
        spi_bits(8'h55, 8, mi, lat);
        cs_finish(dlat);
        check("t5_rxdata", rx_data, 32'h5500_0000);
        check("t5_rxcnt", 32'(rx_cnt), 32'd1);
        check("t5_dones", 32'(done_cnt - d0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
